// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the fetch-PC redirect controller: state encoding and default address width.
package pc_ctrl_pkg;

    localparam int PC_XLEN = 32;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/pc_perf_counter.sv
// Free-running 32-bit event counter with synchronous clear and increment enable; wraps modulo 2^32.
module pc_perf_counter (
    input  logic        clk,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: arbitrates halt / stall / redirect / hazard sources and keeps a redirect alive across stalls.
// Optional build macro PC_PERF_CNT_EN adds stall_cycles and redirect_count outputs.
//
// state | meaning
// RUN   | normal fetch, inputs arbitrated by fixed priority
// PEND  | redirect target latched, waiting for both caches to release
// HALT  | core halted, left only through reset
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] current_pc,
    input  logic [XLEN-1:0] seq_pc,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_target,
    input  logic            load_use_hazard,
    input  logic            icache_stall,
    input  logic            dcache_stall,
    input  logic            halt_req,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            redirect_pending,
`ifdef PC_PERF_CNT_EN
    output logic [31:0]     stall_cycles,
    output logic [31:0]     redirect_count,
`endif
    output logic            halted
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            post_rst_q;
    logic            quiet;

    // Outputs stay inert during reset and for one cycle after it.
    assign quiet = reset | post_rst_q;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        next_pc     = current_pc;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (quiet) begin
            next_pc = RESET_PC;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (dcache_stall) begin
                        if (ex_redirect_valid) begin
                            tgt_d   = ex_redirect_target;
                            state_d = ST_PEND;
                        end
                    end else if (ex_redirect_valid) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (icache_stall) begin
                            tgt_d   = ex_redirect_target;
                            state_d = ST_PEND;
                        end else begin
                            next_pc  = ex_redirect_target;
                            pc_write = 1'b1;
                        end
                    end else if (icache_stall || load_use_hazard) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        next_pc     = seq_pc;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                ST_PEND: begin
                    // Later redirects are ignored here; the first latched target wins.
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (!icache_stall && !dcache_stall) begin
                        next_pc     = tgt_q;
                        pc_write    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            tgt_q      <= '0;
            post_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            post_rst_q <= 1'b0;
        end
    end

    assign redirect_pending = !quiet && (state_q == ST_PEND);
    assign halted           = !quiet && (state_q == ST_HALT);

`ifdef PC_PERF_CNT_EN
    logic stall_inc;
    logic redir_inc;

    // A PC load together with an IF/ID squash only happens when a redirect is applied.
    assign stall_inc = !reset && !pc_write && !halted;
    assign redir_inc = !reset && pc_write && if_id_flush;

    pc_perf_counter u_stall_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (stall_inc),
        .count_o (stall_cycles)
    );

    pc_perf_counter u_redir_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (redir_inc),
        .count_o (redirect_count)
    );
`endif

endmodule
